// File: rtl/bambu_extmem_model_nch.sv
// N-channel off-chip memory responder with per-channel read/write latency, byte-masked writes and slave passthrough.
// Optional per-channel transaction counters are enabled by defining BAMBU_EXTMEM_STATS_EN.
module bambu_extmem_model_nch #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 6,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [N_CH-1:0]          Mout_oe_ram,
    input  logic [N_CH-1:0]          Mout_we_ram,
    input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
    input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [N_CH-1:0]          Sout_DataRdy,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [7:0]               ld_data,
    output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
    output logic [N_CH-1:0]          M_DataRdy,
    output logic [N_CH-1:0]          err_oe_we,
`ifdef BAMBU_EXTMEM_STATS_EN
    input  logic                     stats_clr,
    output logic [N_CH*32-1:0]       rd_count,
    output logic [N_CH*32-1:0]       wr_count,
`endif
    output logic [N_CH-1:0]          err_ovf
);

    localparam int NB      = DATA_W / 8;
    localparam int OFF_W   = ADDR_W + 1;
    localparam int MW      = $clog2(DEPTH);
    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 32'sd1);
    localparam logic [OFF_W-1:0] DEPTH_X = OFF_W'(DEPTH);
    localparam logic [OFF_W:0]   DEPTH_Y = (OFF_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] RD_M1   = CNT_W'(RD_LAT - 32'sd1);
    localparam logic [CNT_W-1:0] WR_M1   = CNT_W'(WR_LAT - 32'sd1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic logic [DATA_W-1:0] mask_f(input logic [SIZE_W-1:0] size);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < DATA_W; b++) m[b] = (b < int'(size));
        return m;
    endfunction

    function automatic logic [OFF_W:0] nbytes_f(input logic [SIZE_W-1:0] size);
        int n;
        n = (int'(size) + 32'sd7) / 32'sd8;
        n = (n > NB) ? NB : n;
        return (OFF_W + 1)'(n);
    endfunction

    logic [7:0]        mem   [DEPTH];
    logic [7:0]        mem_s [DEPTH];
    logic [N_CH-1:0]   commit_s;
    logic [N_CH-1:0]   busy_s;
    logic [OFF_W-1:0]  w_off_s  [N_CH];
    logic [DATA_W-1:0] w_data_s [N_CH];
    logic [DATA_W-1:0] w_mask_s [N_CH];
    logic [OFF_W-1:0]  lim_s;
    logic              ld_ok_s;
    logic [MW-1:0]     ld_idx_s;

    assign lim_s    = {1'b0, base_addr} + DEPTH_X;
    assign ld_ok_s  = ld_en && (busy_s == '0) && ({1'b0, ld_addr} < DEPTH_X);
    assign ld_idx_s = MW'(ld_addr);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t            state_r, state_s;
        logic [CNT_W-1:0]  cnt_r, cnt_s;
        logic              oe, we, req, in_win, start, done, t_rd, cap_rd_r, ovf_hit;
        logic              err_ow_r, err_ovf_r;
        logic [ADDR_W-1:0] a;
        logic [SIZE_W-1:0] size, cap_size_r, t_size;
        logic [OFF_W-1:0]  off, cap_off_r, t_off;
        logic [OFF_W:0]    nbytes;
        logic [DATA_W-1:0] wdata, cap_wdata_r, t_wdata, rd_live, rdata_r, mem_data;

        assign oe     = Mout_oe_ram[c];
        assign we     = Mout_we_ram[c];
        assign req    = oe | we;
        assign a      = Mout_addr_ram[c*ADDR_W +: ADDR_W];
        assign size   = Mout_data_ram_size[c*SIZE_W +: SIZE_W];
        assign wdata  = Mout_Wdata_ram[c*DATA_W +: DATA_W];
        assign in_win = ({1'b0, a} >= {1'b0, base_addr}) && ({1'b0, a} < lim_s);
        assign off    = {1'b0, a} - {1'b0, base_addr};
        assign nbytes = nbytes_f(size);
        assign ovf_hit = (nbytes != '0) && (({1'b0, off} + nbytes) > DEPTH_Y);

        // Live little-endian read; bytes past the window read as zero.
        always_comb begin
            rd_live = '0;
            for (int k = 0; k < NB; k++)
                rd_live[8*k +: 8] = ((off + OFF_W'(k)) < DEPTH_X) ? mem[MW'(off + OFF_W'(k))] : 8'h00;
        end

        // A 1-cycle latency completes in the request cycle itself, so IDLE uses live inputs.
        assign t_rd    = (state_r == IDLE) ? oe      : cap_rd_r;
        assign t_off   = (state_r == IDLE) ? off     : cap_off_r;
        assign t_size  = (state_r == IDLE) ? size    : cap_size_r;
        assign t_wdata = (state_r == IDLE) ? wdata   : cap_wdata_r;
        assign mem_data = (state_r == IDLE) ? rd_live : rdata_r;

        // Next-state and completion decode; oe wins over we.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            start   = 1'b0;
            done    = 1'b0;
            case (state_r)
                IDLE: begin
                    if (req && in_win && reset) begin
                        start = 1'b1;
                        if ((oe ? RD_M1 : WR_M1) == '0) begin
                            done = 1'b1;
                        end else begin
                            state_s = BUSY;
                            cnt_s   = CNT_W'(1);
                        end
                    end else begin
                        cnt_s = '0;
                    end
                end
                BUSY: begin
                    if (cnt_r == (cap_rd_r ? RD_M1 : WR_M1)) begin
                        done    = 1'b1;
                        state_s = IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end

        // State, captured request, read pipeline and sticky error flags.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_r     <= IDLE;
                cnt_r       <= '0;
                cap_rd_r    <= 1'b0;
                cap_off_r   <= '0;
                cap_size_r  <= '0;
                cap_wdata_r <= '0;
                rdata_r     <= '0;
                err_ow_r    <= 1'b0;
                err_ovf_r   <= 1'b0;
            end else begin
                state_r  <= state_s;
                cnt_r    <= cnt_s;
                err_ow_r <= err_ow_r | (oe & we);
                if (start) begin
                    cap_rd_r    <= oe;
                    cap_off_r   <= off;
                    cap_size_r  <= size;
                    cap_wdata_r <= wdata;
                    rdata_r     <= rd_live;
                    err_ovf_r   <= err_ovf_r | ovf_hit;
                end
            end
        end

        assign busy_s[c]   = (state_r == BUSY);
        assign commit_s[c] = done & ~t_rd;
        assign w_off_s[c]  = t_off;
        assign w_data_s[c] = t_wdata;
        assign w_mask_s[c] = mask_f(t_size);

        assign M_DataRdy[c] = done | Sout_DataRdy[c];
        assign M_Rdata_ram[c*DATA_W +: DATA_W] = ((done & t_rd) ? mem_data : '0) | Sout_Rdata_ram[c*DATA_W +: DATA_W];
        assign err_oe_we[c] = err_ow_r;
        assign err_ovf[c]   = err_ovf_r;

`ifdef BAMBU_EXTMEM_STATS_EN
        logic [31:0] rdc_r, wrc_r;

        // Saturating counts of memory-sourced completions.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rdc_r <= 32'd0;
                wrc_r <= 32'd0;
            end else if (stats_clr) begin
                rdc_r <= 32'd0;
                wrc_r <= 32'd0;
            end else begin
                if (done && t_rd && (rdc_r != 32'hFFFF_FFFF)) rdc_r <= rdc_r + 32'd1;
                if (done && !t_rd && (wrc_r != 32'hFFFF_FFFF)) wrc_r <= wrc_r + 32'd1;
            end
        end

        assign rd_count[c*32 +: 32] = rdc_r;
        assign wr_count[c*32 +: 32] = wrc_r;
`endif
    end

    // Next memory image: preload first, then channels in ascending order so the highest index wins.
    always_comb begin
        logic [OFF_W-1:0] idx;
        logic             hit;
        idx   = '0;
        hit   = 1'b0;
        mem_s = mem;
        mem_s[ld_idx_s] = ld_ok_s ? ld_data : mem[ld_idx_s];
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < NB; k++) begin
                idx = w_off_s[c] + OFF_W'(k);
                hit = commit_s[c] && (idx < DEPTH_X) && (w_mask_s[c][8*k +: 8] != 8'h00);
                mem_s[MW'(idx)] = hit ? ((w_data_s[c][8*k +: 8] & w_mask_s[c][8*k +: 8]) |
                                         (mem[MW'(idx)] & ~w_mask_s[c][8*k +: 8]))
                                      : mem_s[MW'(idx)];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        mem <= mem_s;
    end

endmodule

// File: tb/tb_bambu_extmem_model_nch.sv
// Directed bench: RD_LAT=2 and RD_LAT=3 responders share one stimulus stream.
module tb_bambu_extmem_model_nch;
    localparam int N_CH = 2, ADDR_W = 9, DATA_W = 32, SIZE_W = 6;

    logic clock = 1'b0;
    logic reset;
    logic [ADDR_W-1:0]      base_addr, ld_addr;
    logic [N_CH-1:0]        oe, we, sout_rdy;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH*DATA_W-1:0] wdata, sout_data;
    logic [N_CH*SIZE_W-1:0] size;
    logic                   ld_en;
    logic [7:0]             ld_data;
    logic [N_CH*DATA_W-1:0] rdata2, rdata3;
    logic [N_CH-1:0]        rdy2, rdy3, ow2, ow3, ovf2, ovf3;
`ifdef BAMBU_EXTMEM_STATS_EN
    logic                   stats_clr = 1'b0;
    logic [N_CH*32-1:0]     rdc2, wrc2, rdc3, wrc3;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    bambu_extmem_model_nch #(.RD_LAT(2), .WR_LAT(1)) u_dut2 (
        .clock(clock), .reset(reset), .base_addr(base_addr),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .Sout_Rdata_ram(sout_data), .Sout_DataRdy(sout_rdy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .M_Rdata_ram(rdata2), .M_DataRdy(rdy2), .err_oe_we(ow2),
`ifdef BAMBU_EXTMEM_STATS_EN
        .stats_clr(stats_clr), .rd_count(rdc2), .wr_count(wrc2),
`endif
        .err_ovf(ovf2)
    );

    bambu_extmem_model_nch #(.RD_LAT(3), .WR_LAT(1)) u_dut3 (
        .clock(clock), .reset(reset), .base_addr(base_addr),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .Sout_Rdata_ram(sout_data), .Sout_DataRdy(sout_rdy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .M_Rdata_ram(rdata3), .M_DataRdy(rdy3), .err_oe_we(ow3),
`ifdef BAMBU_EXTMEM_STATS_EN
        .stats_clr(stats_clr), .rd_count(rdc3), .wr_count(wrc3),
`endif
        .err_ovf(ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int c, input logic o, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [SIZE_W-1:0] s, input logic [DATA_W-1:0] d);
        oe[c] = o;
        we[c] = w;
        addr[c*ADDR_W +: ADDR_W]  = a;
        size[c*SIZE_W +: SIZE_W]  = s;
        wdata[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic quiet();
        drive(0, 1'b0, 1'b0, 9'h000, 6'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h000, 6'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; base_addr = 9'h000; oe = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
        sout_rdy = 2'b00; sout_data = '0; ld_en = 1'b0; ld_addr = 9'h000; ld_data = 8'h00;
        cyc(); cyc();
        @(negedge clock);
        chk("rst_rdy", 32'(rdy2), 32'h0);
        chk("rst_data", rdata2[31:0], 32'h0);
        chk("rst_err", 32'({ow2, ovf2}), 32'h0);
        cyc(); reset = 1'b1;

        // preload 11 22 33 44 00 00 00 00 at offsets 0..7
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 9'(i); ld_data = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'h00;
            cyc();
        end
        ld_en = 1'b0;

        // test 1: read latency 2 (and 3 on the second responder)
        drive(0, 1'b1, 1'b0, 9'h000, 6'd32, 32'h0);
        @(negedge clock); chk("t1_rdy_t0", 32'(rdy2[0]), 32'h0);
        cyc(); @(negedge clock);
        chk("t1_rdy", 32'(rdy2[0]), 32'h1);
        chk("t1_data", rdata2[31:0], 32'h44332211);
        cyc(); quiet(); @(negedge clock);
        chk("t1_lat3_rdy", 32'(rdy3[0]), 32'h1);
        chk("t1_lat3_data", rdata3[31:0], 32'h44332211);
        cyc();

        // test 2: byte-masked write then read back
        drive(1, 1'b0, 1'b1, 9'h000, 6'd8, 32'hAABBCCDD);
        @(negedge clock); chk("t2_wr_rdy", 32'(rdy2), 32'h2);
        cyc(); quiet(); drive(0, 1'b1, 1'b0, 9'h000, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("t2_data", rdata2[31:0], 32'h443322DD);
        cyc(); quiet(); cyc();

        // test 3: same-byte collision, channel 1 wins
        drive(0, 1'b0, 1'b1, 9'h004, 6'd8, 32'h00000001);
        drive(1, 1'b0, 1'b1, 9'h004, 6'd8, 32'h00000002);
        @(negedge clock); chk("t3_wr_rdy", 32'(rdy2), 32'h3);
        cyc(); quiet(); drive(0, 1'b1, 1'b0, 9'h004, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("t3_data", rdata2[31:0], 32'h00000002);
        cyc(); quiet(); cyc();

        // test 4: oe+we is sticky and treated as a read
        drive(0, 1'b1, 1'b1, 9'h000, 6'd32, 32'hFFFFFFFF);
        cyc(); @(negedge clock);
        chk("t4_err", 32'(ow2), 32'h1);
        chk("t4_rd_data", rdata2[31:0], 32'h443322DD);
        cyc(); quiet();
        repeat (10) cyc();
        @(negedge clock); chk("t4_err_held", 32'(ow2), 32'h1);
        cyc(); reset = 1'b0;
        @(negedge clock); chk("t4_err_rst", 32'(ow2), 32'h0);
        cyc(); reset = 1'b1; drive(0, 1'b1, 1'b0, 9'h000, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("t4_mem_kept", rdata2[31:0], 32'h443322DD);
        cyc(); quiet(); cyc();

        // test 5: out-of-window passthrough
        base_addr = 9'h100;
        drive(0, 1'b1, 1'b0, 9'h010, 6'd32, 32'h0);
        sout_rdy = 2'b01; sout_data[31:0] = 32'h0000CAFE;
        @(negedge clock);
        chk("t5_rdy", 32'(rdy2), 32'h1);
        chk("t5_data", rdata2[31:0], 32'h0000CAFE);
        cyc(); sout_rdy = 2'b00; sout_data = '0;
        @(negedge clock); chk("t5_no_mem_rdy", 32'(rdy2), 32'h0);
        cyc(); quiet(); base_addr = 9'h000; cyc();

        // window end: last byte 255 is fine, last byte 257 overflows
        drive(0, 1'b1, 1'b0, 9'h0FC, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("ovf_edge_ok", 32'(ovf2), 32'h0);
        cyc(); quiet(); cyc(); cyc();
        drive(0, 1'b1, 1'b0, 9'h0FE, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("ovf_set", 32'(ovf2), 32'h1);
        cyc(); quiet(); cyc(); cyc();

        // test 6: reset in second BUSY cycle of a latency-3 read
        drive(0, 1'b1, 1'b0, 9'h000, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("t6_busy1", 32'(rdy3[0]), 32'h0);
        cyc(); reset = 1'b0; quiet();
        @(negedge clock);
        chk("t6_no_pulse", 32'(rdy3[0]), 32'h0);
        chk("t6_ovf_clr", 32'(ovf2), 32'h0);
        cyc(); reset = 1'b1; drive(0, 1'b1, 1'b0, 9'h000, 6'd32, 32'h0);
        cyc(); @(negedge clock); chk("t6_fresh_t1", 32'(rdy3[0]), 32'h0);
        cyc(); @(negedge clock);
        chk("t6_fresh_rdy", 32'(rdy3[0]), 32'h1);
        chk("t6_fresh_data", rdata3[31:0], 32'h443322DD);
        cyc(); quiet(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bambu_extmem_model_nch.md
Name: bambu_extmem_model_nch

Overview:
- Parametrised off-chip memory responder for HLS accelerator simulation benches. It generalises the fixed two-channel, fixed-delay memory model to N channels, each with its own configurable read and write latency.
- Features:
  - byte-masked little-endian writes;
  - address-window decode with passthrough to on-chip slave data;
  - a preload port;
  - sticky protocol-error flags.
- Sits between the accelerator top's master memory bus (Mout_*) and its slave return path (M_Rdata_ram / M_DataRdy).

Parameters:
N_CH, 2, number of independent memory channels
ADDR_W, 9, per-channel byte-address width
DATA_W, 32, per-channel data width (multiple of 8)
SIZE_W, 6, per-channel access-size field width (size in bits)
DEPTH, 256, window size in bytes
RD_LAT, 2, read latency in cycles (>=1)
WR_LAT, 1, write latency in cycles (>=1)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous active-low reset
base_addr  in  ADDR_W  window base; byte address a is in-window iff base_addr <= a < base_addr+DEPTH
Mout_oe_ram  in  N_CH  per-channel read request
Mout_we_ram  in  N_CH  per-channel write request
Mout_addr_ram  in  N_CH*ADDR_W  per-channel byte address, channel c at [c*ADDR_W +: ADDR_W]
Mout_Wdata_ram  in  N_CH*DATA_W  write data
Mout_data_ram_size  in  N_CH*SIZE_W  access size in bits
Sout_Rdata_ram  in  N_CH*DATA_W  on-chip slave read data to merge
Sout_DataRdy  in  N_CH  on-chip slave ready to merge
ld_en  in  1  preload byte write strobe
ld_addr  in  ADDR_W  preload offset from base
ld_data  in  8  preload byte
M_Rdata_ram  out  N_CH*DATA_W  merged read data
M_DataRdy  out  N_CH  merged ready
err_oe_we  out  N_CH  sticky: oe and we both high in a cycle
err_ovf  out  N_CH  sticky: in-window access whose last byte lies at or beyond base_addr+DEPTH

Behaviour:
- Reset (reset=0, async):
  - all channel FSMs go to IDLE; latency counters, read pipelines, M_DataRdy, M_Rdata_ram and error flags clear to 0;
  - pending writes are discarded;
  - memory array contents are NOT cleared.
- Per-channel FSM, states IDLE and BUSY:
  - IDLE -> BUSY on an in-window oe or we, cycle t. The address, write data and size are sampled at t. The master holds its request stable until ready.
  - Read: in-window data is sampled at t; M_DataRdy[c]=1 in cycle t+RD_LAT-1; FSM then returns to IDLE. RD_LAT=1 gives same-cycle combinational ready.
  - Write: M_DataRdy[c]=1 in cycle t+WR_LAT-1; bytes commit at the rising edge ending that cycle; FSM then returns to IDLE.
  - If the request is still held the next cycle, a new transaction starts (back-to-back, no bubble).
- Size and mask:
  - mask = (1<<size)-1; size>=DATA_W gives an all-ones mask.
  - Write merge: new = (wdata & mask) | (old & ~mask).
  - Bytes map little-endian from the address; data beyond the window are not written and read as 0.
- Out-of-window or idle channels:
  - M_DataRdy[c] = Sout_DataRdy[c];
  - M_Rdata_ram[c] = Sout_Rdata_ram[c].
  - In-window channels OR their data and ready with the slave signals.
- Simultaneous events:
  - two channels committing the same byte in one edge: highest channel index wins;
  - a read sampled in the same cycle as another channel's commit returns the old data;
  - ld_en is ignored while any channel is BUSY.
- oe&we on one channel in one cycle: err_oe_we[c] sets and stays set until reset; the request is treated as a read.
- Address wrap: base_addr+DEPTH is computed in ADDR_W+1 bits; no wrap-around of the window.

Optional Feature:
BAMBU_EXTMEM_STATS_EN:
- When defined, adds outputs rd_count and wr_count (N_CH*32 each) and a 1-bit input stats_clr.
- Each counter increments, saturating at 0xFFFFFFFF, on the cycle its channel asserts M_DataRdy from the memory (slave-only readies are not counted).
- stats_clr or reset clears the counters.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. RD_LAT=2, preload bytes 0x11,0x22,0x33,0x44 at offset 0, base 0; ch0 oe addr 0 size 32 -> M_DataRdy[0]=1 in cycle t+1, M_Rdata_ram[31:0]=0x44332211.
2. Ch1 we addr 0 size 8 wdata 0xAABBCCDD over the test-1 contents, then read -> 0x443322DD.
3. Same cycle: ch0 and ch1 write 0x01 and 0x02 to addr 4 -> subsequent read returns 0x02.
4. Ch0 oe and we both high -> err_oe_we=01, remains set after 10 idle cycles; reset clears it while memory still reads 0x443322DD.
5. base_addr=0x100, ch0 oe addr 0x10 with Sout_DataRdy=1, Sout_Rdata=0xCAFE -> same-cycle passthrough ready and data 0xCAFE.
6. RD_LAT=3, reset asserted in the second BUSY cycle -> no M_DataRdy pulse; a fresh request after reset completes in 3 cycles.
